// File: rtl/cmp_flag_reader.sv
// Drives an operand pair onto the ALU comparator, samples its tri-stated flag bus
// after a settle window, retries on illegal encodings and evaluates a branch condition.
module cmp_flag_reader #(
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_RETRY     = 3,
  parameter int ERRW          = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [7:0]      op_a,
  input  logic [7:0]      op_b,
  input  logic [2:0]      cond,
  output logic [7:0]      cmp_a,
  output logic [7:0]      cmp_b,
  output logic            cmp_en,
  input  logic [5:0]      flag_bus,
  output logic            busy,
  output logic            done,
  output logic [5:0]      flags,
  output logic            taken,
  output logic            err,
  output logic [ERRW-1:0] err_cnt
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [5:0] P_GT = 6'b100101;
  localparam logic [5:0] P_LT = 6'b101010;
  localparam logic [5:0] P_EQ = 6'b011100;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [SW-1:0]   r_settle;
  logic [RW-1:0]   r_retry;
  logic [2:0]      r_cond;
  logic [7:0]      r_a, r_b;
  logic [5:0]      r_flags;
  logic            r_taken, r_err;
  logic [ERRW-1:0] r_err_cnt;

  logic            w_legal, w_settled, w_retry_left, w_taken;

  // Case equality so that a floating or X bus is never mistaken for a legal pattern.
  assign w_legal      = (flag_bus === P_GT) || (flag_bus === P_LT) || (flag_bus === P_EQ);
  assign w_settled    = (r_settle == SW'(SETTLE_CYCLES - 1));
  assign w_retry_left = (r_retry < RW'(MAX_RETRY));

  always_comb begin
    w_taken = 1'b0;
    case (r_cond)
      3'd0: w_taken = flag_bus[0];
      3'd1: w_taken = flag_bus[1];
      3'd2: w_taken = flag_bus[2];
      3'd3: w_taken = flag_bus[3];
      3'd4: w_taken = flag_bus[4];
      3'd5: w_taken = flag_bus[5];
      3'd6: w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_DRIVE;
      S_DRIVE:  if (w_settled) w_next = S_SAMPLE;
      S_SAMPLE: w_next = (w_legal || !w_retry_left) ? S_DONE : S_DRIVE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs decode straight from the state register, so reset kills cmp_en at once.
  always_comb begin
    cmp_en = (r_state == S_DRIVE) || (r_state == S_SAMPLE);
    busy   = (r_state != S_IDLE);
    done   = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle  <= '0;
      r_retry   <= '0;
      r_cond    <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_flags   <= '0;
      r_taken   <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_a      <= op_a;
          r_b      <= op_b;
          r_cond   <= cond;
          r_retry  <= '0;
          r_settle <= '0;
        end
        S_DRIVE: if (!w_settled) r_settle <= r_settle + 1'b1;
        S_SAMPLE: begin
          if (w_legal) begin
            r_flags <= flag_bus;
            r_taken <= w_taken;
            r_err   <= 1'b0;
          end else if (w_retry_left) begin
            r_retry  <= r_retry + 1'b1;
            r_settle <= '0;
          end else begin
            r_flags <= '0;
            r_taken <= 1'b0;
            r_err   <= 1'b1;
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmp_a   = r_a;
  assign cmp_b   = r_b;
  assign flags   = r_flags;
  assign taken   = r_taken;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_cmp_flag_reader.sv
// Directed bench for cmp_flag_reader with a behavioural comparator on the flag bus.
module tb_cmp_flag_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] op_a = '0, op_b = '0;
  logic [2:0] cond = '0;
  logic [7:0] cmp_a, cmp_b;
  logic       cmp_en, busy, done, taken, err;
  logic [5:0] flags;
  logic [3:0] err_cnt;
  wire  [5:0] flag_bus;

  logic       float_bus = 1'b0;
  logic       bad_first = 1'b0;
  logic [5:0] model;

  int checks = 0;
  int failures = 0;
  int cyc, en_cyc, extra_done;

  cmp_flag_reader #(.SETTLE_CYCLES(2), .MAX_RETRY(3), .ERRW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cond(cond),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_en(cmp_en), .flag_bus(flag_bus),
    .busy(busy), .done(done), .flags(flags), .taken(taken), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    model[0] = cmp_a >  cmp_b;
    model[1] = cmp_a <  cmp_b;
    model[2] = cmp_a >= cmp_b;
    model[3] = cmp_a <= cmp_b;
    model[4] = cmp_a == cmp_b;
    model[5] = cmp_a != cmp_b;
  end

  assign flag_bus = (cmp_en && !float_bus) ? (bad_first ? 6'b111111 : model) : 6'bzzzzzz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one compare and returns the cycle (relative to the accept edge) in which done rose.
  task automatic run_cmp(input logic [7:0] a, input logic [7:0] b, input logic [2:0] c,
                         input bit poke, output int cycles, output int ens);
    op_a = a; op_b = b; cond = c; start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 1;
    ens = 0;
    while (!done && cycles < 60) begin
      if (cmp_en) ens++;
      if (cycles == 4) bad_first = 1'b0;
      if (poke && cycles == 2) begin
        start = 1'b1; op_a = 8'd1; op_b = 8'd250; cond = 3'd1;
      end
      tick();
      start = 1'b0;
      cycles++;
    end
    if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
    if (poke) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
  endtask

  initial begin
    #12;
    chk("rst_busy",    {31'd0, busy},   32'd0);
    chk("rst_cmp_en",  {31'd0, cmp_en}, 32'd0);
    chk("rst_done",    {31'd0, done},   32'd0);
    chk("rst_flags",   {26'd0, flags},  32'd0);
    chk("rst_err_cnt", {28'd0, err_cnt}, 32'd0);
    chk("rst_cmp_a",   {24'd0, cmp_a},  32'd0);
    rst_n = 1'b1;
    tick();

    run_cmp(8'd200, 8'd17, 3'd0, 1'b0, cyc, en_cyc);
    chk("gt_latency", cyc, 32'd4);
    chk("gt_en_cycles", en_cyc, 32'd3);
    chk("gt_flags", {26'd0, flags}, 32'b100101);
    chk("gt_taken", {31'd0, taken}, 32'd1);
    chk("gt_err",   {31'd0, err},   32'd0);
    tick();
    chk("gt_idle_en", {31'd0, cmp_en}, 32'd0);

    run_cmp(8'd5, 8'd5, 3'd4, 1'b0, cyc, en_cyc);
    chk("eq_flags", {26'd0, flags}, 32'b011100);
    chk("eq_taken", {31'd0, taken}, 32'd1);
    tick();
    run_cmp(8'd5, 8'd5, 3'd5, 1'b0, cyc, en_cyc);
    chk("ne_flags", {26'd0, flags}, 32'b011100);
    chk("ne_taken", {31'd0, taken}, 32'd0);
    tick();
    run_cmp(8'd5, 8'd5, 3'd2, 1'b0, cyc, en_cyc);
    chk("ge_taken", {31'd0, taken}, 32'd1);
    tick();
    run_cmp(8'd9, 8'd3, 3'd7, 1'b0, cyc, en_cyc);
    chk("never_taken", {31'd0, taken}, 32'd0);
    tick();

    float_bus = 1'b1;
    run_cmp(8'd9, 8'd3, 3'd0, 1'b0, cyc, en_cyc);
    chk("z_latency", cyc, 32'd13);
    chk("z_err",     {31'd0, err},     32'd1);
    chk("z_flags",   {26'd0, flags},   32'd0);
    chk("z_taken",   {31'd0, taken},   32'd0);
    chk("z_err_cnt", {28'd0, err_cnt}, 32'd1);
    float_bus = 1'b0;
    tick();

    bad_first = 1'b1;
    run_cmp(8'd3, 8'd9, 3'd1, 1'b0, cyc, en_cyc);
    chk("retry_latency", cyc, 32'd7);
    chk("retry_err",   {31'd0, err},   32'd0);
    chk("retry_flags", {26'd0, flags}, 32'b101010);
    chk("retry_taken", {31'd0, taken}, 32'd1);
    chk("retry_err_cnt", {28'd0, err_cnt}, 32'd1);
    tick();

    run_cmp(8'd77, 8'd66, 3'd0, 1'b1, cyc, en_cyc);
    chk("poke_latency", cyc, 32'd4);
    chk("poke_flags", {26'd0, flags}, 32'b100101);
    chk("poke_cmp_a", {24'd0, cmp_a}, 32'd77);
    extra_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) extra_done++;
      tick();
    end
    chk("poke_no_second", extra_done, 32'd0);

    op_a = 8'd1; op_b = 8'd2; cond = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("mid_cmp_en", {31'd0, cmp_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cmp_en",  {31'd0, cmp_en},  32'd0);
    chk("arst_busy",    {31'd0, busy},    32'd0);
    chk("arst_flags",   {26'd0, flags},   32'd0);
    chk("arst_err_cnt", {28'd0, err_cnt}, 32'd0);
    #3 rst_n = 1'b1;
    extra_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) extra_done++;
    end
    chk("arst_no_done", extra_done, 32'd0);

    run_cmp(8'd4, 8'd4, 3'd6, 1'b0, cyc, en_cyc);
    chk("always_taken", {31'd0, taken}, 32'd1);
    tick();

    float_bus = 1'b1;
    for (int i = 0; i < 16; i++) begin
      run_cmp(8'(i), 8'd100, (i == 15) ? 3'd6 : 3'd3, 1'b0, cyc, en_cyc);
      if (i == 13) chk("sat_cnt_14", {28'd0, err_cnt}, 32'd14);
      tick();
    end
    chk("sat_err_cnt", {28'd0, err_cnt}, 32'd15);
    chk("sat_err", {31'd0, err}, 32'd1);
    chk("always_fail_taken", {31'd0, taken}, 32'd0);
    float_bus = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
